// File: rtl/slicel_cfg_loader.sv
// Byte-serial configuration sequencer for one slicel: assembles a frame in a shadow
// register, commits it with a one-cycle cen pulse. Optional: SLICEL_CFG_PARITY_EN.
module slicel_cfg_loader #(
   parameter  int S_XX_BASE = 4,
   parameter  int NUM_LUTS  = 4,
   parameter  int WORD_W    = 8,
   localparam int CFG_SIZE  = 2*2**S_XX_BASE+1,
   localparam int MUX_LVLS  = $clog2(NUM_LUTS),
   localparam int FRAME_W   = CFG_SIZE*NUM_LUTS + MUX_LVLS + 1 + 2*NUM_LUTS,
   localparam int NUM_WORDS = (FRAME_W + WORD_W - 1) / WORD_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_start,
   input  logic                         cfg_abort,
   input  logic                         in_valid,
   input  logic [WORD_W-1:0]            in_data,
`ifdef SLICEL_CFG_PARITY_EN
   input  logic                         in_parity,
`endif
   output logic                         in_ready,
   input  logic                         user_reg_ce,
   output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_out,
   output logic [MUX_LVLS-1:0]          inter_lut_mux_config_out,
   output logic                         config_use_cc_out,
   output logic [2*NUM_LUTS-1:0]        regs_config_out,
   output logic                         cen,
   output logic                         reg_ce,
   output logic                         busy,
   output logic                         cfg_done,
   output logic                         cfg_err
);
   localparam int CNT_W = $clog2(NUM_WORDS+1);
   localparam int FI_W  = $clog2(FRAME_W);
   localparam int WI_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int LUT_W = CFG_SIZE*NUM_LUTS;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [FRAME_W-1:0]   shadow, shadow_nxt;
   logic                 done_q;
   logic                 wr_en, clr_cnt;

`ifdef SLICEL_CFG_PARITY_EN
   logic par_ok, set_err, err_q;
   assign par_ok = ((^in_data) == in_parity);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Abort outranks a coincident word; a bad-parity word is never written.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      clr_cnt   = 1'b0;
`ifdef SLICEL_CFG_PARITY_EN
      set_err   = 1'b0;
`endif
      case (state)
         IDLE: if (cfg_start) begin
            state_nxt = LOAD;
            clr_cnt   = 1'b1;
         end
         LOAD: if (cfg_abort) begin
            state_nxt = IDLE;
         end else if (in_valid) begin
`ifdef SLICEL_CFG_PARITY_EN
            if (!par_ok) begin
               state_nxt = IDLE;
               set_err   = 1'b1;
            end else
`endif
            begin
               wr_en = 1'b1;
               if (cnt == CNT_W'(NUM_WORDS-1)) state_nxt = COMMIT;
            end
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Word k lands on shadow bits [WORD_W*k +: WORD_W]; bits past FRAME_W fall off.
   always_comb begin
      shadow_nxt = shadow;
      for (int b = 0; b < FRAME_W; b++)
         if (wr_en && cnt == CNT_W'(b / WORD_W))
            shadow_nxt[FI_W'(b)] = in_data[WI_W'(b % WORD_W)];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         shadow <= '0;
         done_q <= 1'b0;
      end else begin
         shadow <= shadow_nxt;
         done_q <= (state == COMMIT);
         if (clr_cnt)    cnt <= '0;
         else if (wr_en) cnt <= cnt + 1'b1;
      end
   end

`ifdef SLICEL_CFG_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err_q <= 1'b0;
      else if (clr_cnt) err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
   end
   assign cfg_err = err_q;
`else
   assign cfg_err = 1'b0;
`endif

   assign in_ready = (state == LOAD);
   assign busy     = (state != IDLE);
   assign cen      = (state == COMMIT);
   assign cfg_done = done_q;
   // rst_n term keeps reg_ce low while reset is held, not just after the state clears.
   assign reg_ce   = user_reg_ce & ~busy & rst_n;

   assign luts_config_out          = shadow[LUT_W-1:0];
   assign inter_lut_mux_config_out = shadow[LUT_W +: MUX_LVLS];
   assign config_use_cc_out        = shadow[LUT_W+MUX_LVLS];
   assign regs_config_out          = shadow[FRAME_W-1 -: 2*NUM_LUTS];
endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Directed bench for slicel_cfg_loader at default parameters (143-bit frame, 18 words).
// Covers the SLICEL_CFG_PARITY_EN build when that macro is defined.
module tb_slicel_cfg_loader;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start = 1'b0, cfg_abort = 1'b0, in_valid = 1'b0, user_reg_ce = 1'b1;
   logic [7:0]   in_data = '0;
`ifdef SLICEL_CFG_PARITY_EN
   logic         in_parity = 1'b0;
`endif
   logic         in_ready, config_use_cc_out, cen, reg_ce, busy, cfg_done, cfg_err;
   logic [131:0] luts_config_out;
   logic [1:0]   inter_lut_mux_config_out;
   logic [7:0]   regs_config_out;

   int n_vec = 0, n_err = 0, cen_cnt = 0, done_cnt = 0;
   int cyc, c0, d0;

   // Expected frames: luts = low 132 bits, mux = bits 133:132, use_cc = bit 134,
   // regs = {word17[6:0], word16[7]}.
   localparam logic [131:0] LUTS_A5 = {4'h5, {16{8'hA5}}};
   localparam logic [131:0] LUTS_3C = {4'hC, {16{8'h3C}}};
   localparam logic [131:0] LUTS_AB = {4'h5, {7{8'hA5}}, {9{8'h11}}};

   slicel_cfg_loader dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .in_valid(in_valid), .in_data(in_data),
`ifdef SLICEL_CFG_PARITY_EN
      .in_parity(in_parity),
`endif
      .in_ready(in_ready), .user_reg_ce(user_reg_ce),
      .luts_config_out(luts_config_out),
      .inter_lut_mux_config_out(inter_lut_mux_config_out),
      .config_use_cc_out(config_use_cc_out), .regs_config_out(regs_config_out),
      .cen(cen), .reg_ce(reg_ce), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cen)      cen_cnt  <= cen_cnt + 1;
      if (cfg_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic ab);
      cfg_start = 1'b1;
      cfg_abort = ab;
      step();
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
   endtask

   // Presents n words of val; word index 'bad' carries wrong parity (parity build only).
   task automatic feed(input logic [7:0] val, input bit gaps, input int n, input int bad,
                       output int ncyc);
      int acc = 0;
      ncyc = 0;
      in_data = val;
      while (acc < n && ncyc < 100) begin
         in_valid = gaps ? (ncyc % 2 == 0) : 1'b1;
`ifdef SLICEL_CFG_PARITY_EN
         in_parity = (^val) ^ (acc == bad);
`endif
         if (gaps && ncyc == 5) cfg_start = 1'b1;
         step();
         cfg_start = 1'b0;
         if (in_valid) acc++;
         if (acc < n) begin
            chk("busy_load", busy, 1);
            chk("reg_ce_load", reg_ce, 0);
         end
         ncyc++;
      end
      in_valid = 1'b0;
      chk("accepts", acc, n);
   endtask

   task automatic chk_frame(input string tag, input logic [131:0] l, input logic [1:0] m,
                            input logic u, input logic [7:0] r);
      chk({tag, "_luts"}, luts_config_out, l);
      chk({tag, "_mux"}, inter_lut_mux_config_out, m);
      chk({tag, "_usecc"}, config_use_cc_out, u);
      chk({tag, "_regs"}, regs_config_out, r);
   endtask

   // Called right after the final accepting edge.
   task automatic chk_commit(input string tag, input logic [131:0] l, input logic [1:0] m,
                             input logic u, input logic [7:0] r);
      chk({tag, "_cen"}, cen, 1);
      chk({tag, "_busy_commit"}, busy, 1);
      chk({tag, "_reg_ce_commit"}, reg_ce, 0);
      chk_frame(tag, l, m, u, r);
      step();
      chk({tag, "_cen_once"}, cen, 0);
      chk({tag, "_done"}, cfg_done, 1);
      chk({tag, "_reg_ce_done"}, reg_ce, 1);
      step();
      chk({tag, "_done_once"}, cfg_done, 0);
   endtask

   initial begin
      #3;
      chk("rst_cen", cen, 0);
      chk("rst_reg_ce", reg_ce, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);
      chk_frame("rst", '0, '0, 1'b0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("idle_reg_ce", reg_ce, 1);
      chk("idle_ready", in_ready, 0);

      // back-to-back 0xA5 frame
      c0 = cen_cnt; d0 = done_cnt;
      start_load(1'b0);
      chk("load_ready", in_ready, 1);
      feed(8'hA5, 1'b0, 18, -1, cyc);
      chk("b2b_latency", cyc, 18);
      chk_commit("a5", LUTS_A5, 2'd2, 1'b0, 8'h4B);
      chk("a5_cen_count", cen_cnt - c0, 1);
      chk("a5_done_count", done_cnt - d0, 1);

      // gapped valid, stray cfg_start mid-load must not restart the counter
      start_load(1'b0);
      feed(8'hA5, 1'b1, 18, -1, cyc);
      chk("gap_latency", cyc, 35);
      chk_commit("gap", LUTS_A5, 2'd2, 1'b0, 8'h4B);

      // abort after 9 words; coincident 10th word must be dropped
      c0 = cen_cnt; d0 = done_cnt;
      start_load(1'b0);
      feed(8'h11, 1'b0, 9, -1, cyc);
      cfg_abort = 1'b1; in_valid = 1'b1; in_data = 8'h22;
      step();
      cfg_abort = 1'b0; in_valid = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", in_ready, 0);
      chk_frame("abort", LUTS_AB, 2'd2, 1'b0, 8'h4B);
      step(); step();
      chk("abort_no_cen", cen_cnt - c0, 0);
      chk("abort_no_done", done_cnt - d0, 0);

      // start and abort together in IDLE: start wins
      start_load(1'b1);
      chk("start_wins", in_ready, 1);
      feed(8'h3C, 1'b0, 18, -1, cyc);
      chk_commit("3c", LUTS_3C, 2'd3, 1'b0, 8'h78);

      // asynchronous reset mid-load
      c0 = cen_cnt;
      start_load(1'b0);
      feed(8'h11, 1'b0, 10, -1, cyc);
      #2 rst_n = 1'b0;
      #1;
      chk_frame("arst", '0, '0, 1'b0, '0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", in_ready, 0);
      chk("arst_cen", cen, 0);
      chk("arst_reg_ce", reg_ce, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("arst_no_cen", cen_cnt - c0, 0);
      start_load(1'b0);
      feed(8'h77, 1'b0, 1, -1, cyc);
      chk("restart_word0", luts_config_out[15:0], 16'h0077);
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0;
      chk("restart_abort", busy, 0);

`ifdef SLICEL_CFG_PARITY_EN
      c0 = cen_cnt; d0 = done_cnt;
      start_load(1'b0);
      feed(8'h5A, 1'b0, 6, 5, cyc);
      chk("par_err", cfg_err, 1);
      chk("par_ready", in_ready, 0);
      chk("par_busy", busy, 0);
      chk("par_word5_dropped", luts_config_out[47:40], 8'h00);
      step();
      chk("par_err_sticky", cfg_err, 1);
      chk("par_no_cen", cen_cnt - c0, 0);
      chk("par_no_done", done_cnt - d0, 0);
      start_load(1'b0);
      chk("par_err_clear", cfg_err, 0);
      feed(8'hA5, 1'b0, 18, -1, cyc);
      chk_commit("par_a5", LUTS_A5, 2'd2, 1'b0, 8'h4B);
`else
      chk("err_tied", cfg_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
